// File: rtl/fetch_unit_pkg.sv
// Shared core constants: fetch FSM encodings, default boot address, ALU op codes.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH_ST_RESET = 2'b00,
      FETCH_ST_FETCH = 2'b01
   } fetch_state_e;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLL  = 4'd6,
      ALU_SRL  = 4'd7
   } alu_op_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, decode handshake and redirect.
interface fetch_unit_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        instr_valid_o;
   logic [31:0] instr_data_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;

   modport master (
      output imem_req_o, imem_addr_o, instr_valid_o, instr_data_o, instr_pc_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, instr_valid_o, instr_data_o, instr_pc_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
   );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO with flush; storage is cleared on reset so outputs read zero.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr] <= wdata;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   assign rdata = mem_q[rd_ptr];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited memory reads, in-order response buffering, redirect flush.
//   state          | meaning
//   FETCH_ST_RESET | held in reset and for one cycle after release; no requests
//   FETCH_ST_FETCH | issuing reads while credit allows
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   fetch_unit_if.master bus
);
   localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q;
   logic [31:0]   resp_pc_q;
   logic [CW-1:0] outstanding_q;
   logic [CW-1:0] discard_q;
   logic [CW-1:0] fifo_count;
   logic [63:0]   fifo_head;
   logic          fifo_full, fifo_empty;
   logic          credit_ok, req, fire, resp, push, pop, valid;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= FETCH_ST_RESET;
      else       state_q <= state_d;
   end

   assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_W;

   always_comb begin
      state_d = FETCH_ST_RESET;
      req     = 1'b0;
      case (state_q)
         FETCH_ST_RESET: state_d = FETCH_ST_FETCH;
         FETCH_ST_FETCH: begin
            state_d = FETCH_ST_FETCH;
            req     = !bus.redirect_i && credit_ok;
         end
         default:        state_d = FETCH_ST_RESET;
      endcase
   end

   // A response with nothing outstanding belongs to a request from before reset.
   assign fire  = req && bus.imem_gnt_i;
   assign resp  = bus.imem_rvalid_i && (outstanding_q != '0);
   assign push  = resp && (discard_q == '0) && !bus.redirect_i;
   assign valid = !fifo_empty && !bus.redirect_i;
   assign pop   = valid && bus.instr_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         outstanding_q <= outstanding_q + CW'(fire) - CW'(resp);
         if (bus.redirect_i) begin
            fetch_pc_q <= word_align(bus.redirect_pc_i);
            resp_pc_q  <= word_align(bus.redirect_pc_i);
            discard_q  <= outstanding_q + CW'(fire) - CW'(resp);
         end else begin
            if (fire) fetch_pc_q <= fetch_pc_q + PC_STEP;
            if (push) resp_pc_q  <= resp_pc_q + PC_STEP;
            if (resp && (discard_q != '0)) discard_q <= discard_q - 1'b1;
         end
      end
   end

   fetch_fifo #(
      .WIDTH (64),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect_i),
      .wdata ({resp_pc_q, bus.imem_rdata_i}),
      .rdata (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.imem_req_o    = req;
   assign bus.imem_addr_o   = fetch_pc_q;
   assign bus.instr_valid_o = valid;
   assign bus.instr_data_o  = fifo_head[31:0];
   assign bus.instr_pc_o    = fifo_head[63:32];

   overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && fifo_full && !pop));

endmodule
